// File: rtl/regfile_rd_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_rd_arbiter_if
// Description : Bundle of request, grant and read-port signals shared between
//               the register-file read arbiter and its environment.
//                 req   - per-requester request level
//                 addr  - flattened addresses, requester i at [i*AW +: AW]
//                 stall - suppresses new grants while high
//                 gnt   - one-hot grant pulse
//                 sel   - select driven to the register-file read port
//                 ydata - combinational read-port output for sel
//                 rvalid/rid/rdata - returned read data tagged with requester
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_rd_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int IDW  = 3
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr;
  logic               stall;
  logic [NREQ-1:0]    gnt;
  logic [AW-1:0]      sel;
  logic [DW-1:0]      ydata;
  logic               rvalid;
  logic [IDW-1:0]     rid;
  logic [DW-1:0]      rdata;

  // Arbiter side
  modport slave (
    input  req, addr, stall, ydata,
    output gnt, sel, rvalid, rid, rdata
  );

  // Requesters plus register file side
  modport master (
    output req, addr, stall, ydata,
    input  gnt, sel, rvalid, rid, rdata
  );
endinterface
`default_nettype wire

// File: rtl/regfile_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_rd_arbiter
// Description : Round-robin arbiter sharing one register-file read port among
//               NREQ requesters. A grant drives the port select; the word read
//               back is captured one cycle later and returned with the ID of
//               the requester it belongs to. Register 0 always reads as zero.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - regfile_rd_arbiter_if.slave (req/addr/stall/ydata in,
//                       gnt/sel/rvalid/rid/rdata out)
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_rd_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int IDW  = 3
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  regfile_rd_arbiter_if.slave  bus
);

  localparam logic [IDW-1:0]  C_LAST = IDW'(NREQ - 1);
  localparam logic [NREQ-1:0] C_ONE  = NREQ'(1);

  logic [NREQ-1:0] r_gnt;
  logic [AW-1:0]   r_sel;
  logic            r_inflight;
  logic [IDW-1:0]  r_id;
  logic [IDW-1:0]  r_ptr;
  logic            r_rvalid;
  logic [IDW-1:0]  r_rid;
  logic [DW-1:0]   r_rdata;

  logic [NREQ-1:0] w_elig;
  logic            w_found;
  logic [IDW-1:0]  w_win;
  logic [AW-1:0]   w_win_addr;
  logic [IDW-1:0]  w_ptr_nxt;
  int              w_dist;
  int              w_best;

  // A requester whose grant pulse is high right now is skipped, so a held
  // request cannot be granted on two consecutive edges.
  assign w_elig = bus.req & ~r_gnt;

  // Winner is the eligible requester with the smallest circular distance
  // from the priority pointer.
  always_comb begin
    w_win  = '0;
    w_dist = 0;
    w_best = NREQ;
    for (int k = 0; k < NREQ; k++) begin
      w_dist = k - int'(r_ptr);
      if (w_dist < 0) begin
        w_dist = w_dist + NREQ;
      end
      if (w_elig[k] && (w_dist < w_best)) begin
        w_best = w_dist;
        w_win  = IDW'(k);
      end
    end
    w_found = (w_best < NREQ);
  end

  always_comb begin
    w_win_addr = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_win == IDW'(k)) begin
        w_win_addr = bus.addr[k*AW +: AW];
      end
    end
  end

  assign w_ptr_nxt = (w_win == C_LAST) ? '0 : (w_win + 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt      <= '0;
      r_sel      <= '0;
      r_inflight <= 1'b0;
      r_id       <= '0;
      r_ptr      <= '0;
      r_rvalid   <= 1'b0;
      r_rid      <= '0;
      r_rdata    <= '0;
    end else begin
      // Grant stage
      if (!bus.stall && w_found) begin
        r_gnt      <= C_ONE << w_win;
        r_sel      <= w_win_addr;
        r_inflight <= 1'b1;
        r_id       <= w_win;
        r_ptr      <= w_ptr_nxt;
      end else begin
        r_gnt      <= '0;
        r_inflight <= 1'b0;
      end

      // Capture stage: runs regardless of stall so an issued read completes.
      if (r_inflight) begin
        r_rvalid <= 1'b1;
        r_rid    <= r_id;
        r_rdata  <= (r_sel == '0) ? '0 : bus.ydata;
      end else begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign bus.gnt    = r_gnt;
  assign bus.sel    = r_sel;
  assign bus.rvalid = r_rvalid;
  assign bus.rid    = r_rid;
  assign bus.rdata  = r_rdata;

endmodule
`default_nettype wire
